// File: rtl/baud_gen_pkg.sv
// Shared defaults and the 12 MHz divisor preset table for the baud-rate generator.
package baud_gen_pkg;

  localparam int OVS_DEF    = 16;
  localparam int DIV_MIN    = 2;
  localparam int DIV_W_DEF  = 16;
  localparam int FRAC_W_DEF = 4;

  // 12 MHz system clock, 16x oversampling: integer / sixteenths of a cycle
  localparam int PRESET_9600_INT    = 78;
  localparam int PRESET_9600_FRAC   = 2;
  localparam int PRESET_19200_INT   = 39;
  localparam int PRESET_19200_FRAC  = 1;
  localparam int PRESET_38400_INT   = 19;
  localparam int PRESET_38400_FRAC  = 9;
  localparam int PRESET_57600_INT   = 13;
  localparam int PRESET_57600_FRAC  = 0;
  localparam int PRESET_115200_INT  = 6;
  localparam int PRESET_115200_FRAC = 8;

  typedef enum logic [2:0] {
    BAUD_9600,
    BAUD_19200,
    BAUD_38400,
    BAUD_57600,
    BAUD_115200
  } baud_sel_e;

  typedef struct packed {
    logic [15:0] div_int;
    logic [3:0]  div_frac;
  } baud_preset_t;

  function automatic baud_preset_t preset_12m(input baud_sel_e sel);
    baud_preset_t p;
    p = '0;
    case (sel)
      BAUD_9600:   p = '{div_int: 16'(PRESET_9600_INT),   div_frac: 4'(PRESET_9600_FRAC)};
      BAUD_19200:  p = '{div_int: 16'(PRESET_19200_INT),  div_frac: 4'(PRESET_19200_FRAC)};
      BAUD_38400:  p = '{div_int: 16'(PRESET_38400_INT),  div_frac: 4'(PRESET_38400_FRAC)};
      BAUD_57600:  p = '{div_int: 16'(PRESET_57600_INT),  div_frac: 4'(PRESET_57600_FRAC)};
      BAUD_115200: p = '{div_int: 16'(PRESET_115200_INT), div_frac: 4'(PRESET_115200_FRAC)};
      default:     p = '{div_int: 16'(PRESET_9600_INT),   div_frac: 4'(PRESET_9600_FRAC)};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/baud_div_core.sv
// Period counter with optional fractional accumulator (BAUD_GEN_FRAC_EN).
// wrap is high for the enabled cycle that ends a period.
module baud_div_core
  import baud_gen_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [DIV_W-1:0]  act_int,
  input  logic [FRAC_W-1:0] act_frac,
  output logic              wrap
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last;

`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic              carry;
  logic [FRAC_W:0]   sum;

  // A carry out of the previous period stretches this one by one cycle.
  assign last = act_int - DIV_W'(1) + DIV_W'(carry);
  assign sum  = {1'b0, acc} + {1'b0, act_frac};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (wrap) begin
      acc   <= sum[FRAC_W-1:0];
      carry <= sum[FRAC_W];
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^act_frac;
  assign last        = act_int - DIV_W'(1);
`endif

  assign wrap = en && !clr && (cnt == last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == last) cnt <= '0;
      else             cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/baud_gen.sv
// Fractional baud-rate generator: divisor shadowing plus oversample/mid/bit ticks.
// Fractional divisor support is compiled in only with BAUD_GEN_FRAC_EN defined.
module baud_gen
  import baud_gen_pkg::*;
#(
  parameter int DIV_W    = DIV_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF,
  parameter int OVS      = OVS_DEF,
  parameter int DIV_RST  = PRESET_9600_INT,
  parameter int FRAC_RST = PRESET_9600_FRAC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              tick_ovs,
  output logic              tick_mid,
  output logic              tick_bit,
  output logic              cfg_err
);

  localparam int OVS_W = $clog2(OVS);

  logic [DIV_W-1:0]  act_int;
  logic [DIV_W-1:0]  pend_int;
  logic [FRAC_W-1:0] act_frac;
  logic              pend_vld;
  logic              load_ok;
  logic              load_bad;
  logic              apply_now;
  logic              clr;
  logic              wrap;
  logic [OVS_W-1:0]  ovs_cnt;

  // div_load is a single-cycle pulse; no handshake. A valid load applies at
  // once when sync coincides or the counter is idle, else at the next period end.
  assign load_ok   = div_load && (div_int >= DIV_W'(DIV_MIN));
  assign load_bad  = div_load && !load_ok;
  assign apply_now = load_ok && (sync || !en);
  assign clr       = sync || apply_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_int  <= DIV_W'(DIV_RST);
      pend_int <= '0;
      pend_vld <= 1'b0;
    end else if (apply_now || (load_ok && wrap)) begin
      act_int  <= div_int;
      pend_vld <= 1'b0;
    end else if (load_ok) begin
      pend_int <= div_int;
      pend_vld <= 1'b1;
    end else if (wrap && pend_vld) begin
      act_int  <= pend_int;
      pend_vld <= 1'b0;
    end
  end

`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] pend_frac;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_frac  <= FRAC_W'(FRAC_RST);
      pend_frac <= '0;
    end else if (apply_now || (load_ok && wrap)) begin
      act_frac  <= div_frac;
    end else if (load_ok) begin
      pend_frac <= div_frac;
    end else if (wrap && pend_vld) begin
      act_frac  <= pend_frac;
    end
  end
`else
  localparam int unused_frac_rst = FRAC_RST;
  logic unused_div_frac;
  assign unused_div_frac = ^div_frac;
  assign act_frac        = '0;
`endif

  baud_div_core #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .act_int  (act_int),
    .act_frac (act_frac),
    .wrap     (wrap)
  );

  // Mid/bit ticks are decoded from the count before increment so they line up with tick_ovs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_ovs <= 1'b0;
      tick_mid <= 1'b0;
      tick_bit <= 1'b0;
      cfg_err  <= 1'b0;
      ovs_cnt  <= '0;
    end else begin
      tick_ovs <= wrap;
      tick_mid <= wrap && (ovs_cnt == OVS_W'(OVS/2 - 1));
      tick_bit <= wrap && (ovs_cnt == OVS_W'(OVS - 1));
      cfg_err  <= load_bad;
      if (clr)       ovs_cnt <= '0;
      else if (wrap) ovs_cnt <= ovs_cnt + OVS_W'(1);
    end
  end

endmodule

// File: tb/tb_baud_gen.sv
// Directed bench for baud_gen: tick spacing, fractional stretch, loads, sync, hold and reset.
module tb_baud_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sync;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        tick_ovs;
  logic        tick_mid;
  logic        tick_bit;
  logic        cfg_err;

  int vectors     = 0;
  int miscompares = 0;

`ifdef BAUD_GEN_FRAC_EN
  localparam int FRAC_ON = 1;
`else
  localparam int FRAC_ON = 0;
`endif

  baud_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync     (sync),
    .div_int  (div_int),
    .div_frac (div_frac),
    .div_load (div_load),
    .tick_ovs (tick_ovs),
    .tick_mid (tick_mid),
    .tick_bit (tick_bit),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts negedges until the selected tick is seen; -1 if the budget runs out.
  task automatic wait_sig(input int sel, input int budget, output int n);
    logic hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       hit = tick_ovs;
        1:       hit = tick_mid;
        default: hit = tick_bit;
      endcase
    end
    if (!hit) n = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int di, input int df);
    div_int  = 16'(di);
    div_frac = 4'(df);
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
  endtask

  initial begin
    int r;
    int r2;
    int tot;
    int n79;
    int hold;

    rst_n = 1'b0; en = 1'b0; sync = 1'b0; div_load = 1'b0;
    div_int = '0; div_frac = '0;
    idle(2);
    check("reset_outputs", {28'd0, tick_ovs, tick_mid, tick_bit, cfg_err}, 32'd0);

    // Reset defaults 78/2
    en = 1'b1; rst_n = 1'b1;
    wait_sig(0, 200, r);
    check("first_tick", r, 78);
    tot = 0; n79 = 0;
    for (int i = 0; i < 8; i++) begin
      wait_sig(0, 200, r);
      tot += r;
      if (r == 79) n79++;
    end
    check("eight_periods_total", tot, 624 + FRAC_ON);
    check("eight_periods_long", n79, FRAC_ON);

    // Rejected load
    load(1, 0);
    check("cfg_err_pulse", cfg_err, 1);
    idle(1);
    check("cfg_err_clear", cfg_err, 0);
    wait_sig(0, 200, r);
    check("period_after_reject", 2 + r, 78);
    tot = 0; n79 = 0;
    for (int i = 0; i < 8; i++) begin
      wait_sig(0, 200, r);
      tot += r;
      if (r == 79) n79++;
    end
    check("reject_periods_total", tot, 624 + FRAC_ON);
    check("reject_periods_long", n79, FRAC_ON);

    // Sync at period count 10
    idle(10);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check("sync_no_tick", tick_ovs, 0);
    wait_sig(0, 200, r);
    check("sync_first_tick", r, 78);
    wait_sig(1, 2000, r);
    check("sync_mid_after", r, 7 * 78);
    wait_sig(2, 2000, r);
    check("sync_bit_after", r, 8 * 78 + FRAC_ON);
    wait_sig(0, 200, r);
    check("carry_period", r, 78 + FRAC_ON);

    // Load 6/0 at period count 40 while running
    idle(40);
    load(6, 0);
    wait_sig(0, 200, r);
    check("load_period_end", 41 + r, 78);
    for (int i = 0; i < 3; i++) begin
      wait_sig(0, 200, r);
      check("new_period_6", r, 6);
    end

    // 57600 preset applied while idle
    en = 1'b0;
    load(13, 0);
    en = 1'b1;
    wait_sig(1, 2000, r);
    check("mid_first", r, 104);
    wait_sig(2, 2000, r2);
    check("bit_first", r + r2, 208);
    wait_sig(1, 2000, r);
    check("mid_after_bit", r, 104);
    wait_sig(2, 2000, r2);
    check("bit_period", r + r2, 208);
    wait_sig(0, 200, r);
    check("ovs_period_13", r, 13);

    // Hold with en low
    idle(5);
    en = 1'b0;
    hold = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick_ovs || tick_mid || tick_bit) hold++;
    end
    check("hold_no_ticks", hold, 0);
    en = 1'b1;
    wait_sig(0, 200, r);
    check("resume_count", r, 8);

    // Reset while tick_mid is high
    wait_sig(1, 2000, r);
    check("mid_found", r > 0, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {28'd0, tick_ovs, tick_mid, tick_bit, cfg_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sig(0, 200, r);
    check("tick_after_reset", r, 78);

    // Pending load discarded by reset
    idle(5);
    load(6, 0);
    idle(3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_sig(0, 200, r);
    check("discard_first", r, 78);
    wait_sig(0, 200, r);
    check("discard_second", r, 78);

    // Second load overwrites the pending one
    load(6, 0);
    load(13, 0);
    wait_sig(0, 200, r);
    check("overwrite_period_end", 2 + r, 78);
    wait_sig(0, 200, r);
    check("overwrite_applied", r, 13);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/baud_gen.md
BAUD_GEN -- requirements
Module: baud_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the integer divisor.
REQ-002 SHALL have parameter FRAC_W, default 4, width of the fractional divisor.
REQ-003 SHALL have parameter OVS, default 16, oversample ticks per bit period (power of two, >= 4).
REQ-004 SHALL have parameter DIV_RST, default 78, integer divisor after reset.
REQ-005 SHALL have parameter FRAC_RST, default 2, fractional divisor after reset (12 MHz, 9600 baud, 16x).
REQ-006 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-007 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports: en  in  1  count enable; low freezes all counters and suppresses ticks.
REQ-009 SHALL have ports: sync  in  1  one-cycle pulse that restarts the period, fractional and oversample counters.
REQ-010 SHALL have ports: div_int  in  DIV_W  requested integer divisor.
REQ-011 SHALL have ports: div_frac  in  FRAC_W  requested fractional divisor, units of 1/2^FRAC_W cycle.
REQ-012 SHALL have ports: div_load  in  1  one-cycle pulse capturing div_int/div_frac.
REQ-013 SHALL have ports: tick_ovs  out  1  one-cycle oversample tick.
REQ-014 SHALL have ports: tick_mid  out  1  one-cycle tick at mid-bit (oversample count OVS/2).
REQ-015 SHALL have ports: tick_bit  out  1  one-cycle tick at bit boundary.
REQ-016 SHALL have ports: cfg_err  out  1  one-cycle pulse when a load is rejected.

Function
REQ-017 SHALL keep an active divisor pair (act_int, act_frac) and a pending pair with a pending flag.
REQ-018 SHALL use period length act_int, or act_int+1 when the fractional accumulator carried at the previous tick.
REQ-019 SHALL, per enabled cycle, increment the period counter; at period-1, clear it, add act_frac to the FRAC_W-bit accumulator (wrap mod 2^FRAC_W, carry to next period), and register tick_ovs high for the next cycle.
REQ-020 SHALL produce the first tick_ovs after exactly act_int enabled edges following reset release or sync.
REQ-021 SHALL yield average tick_ovs period act_int + act_frac/2^FRAC_W cycles.
REQ-022 SHALL count tick_ovs in a log2(OVS)-bit counter, wrapping OVS-1 -> 0; tick_bit asserts with the tick_ovs causing the wrap; tick_mid asserts with the tick_ovs setting it to OVS/2.
REQ-023 SHALL reject div_load with div_int < 2: cfg_err pulses next cycle, active and pending pairs unchanged.
REQ-024 SHALL, on valid div_load with en high, set the pending pair and apply it at the next period boundary; the current period completes with old values.
REQ-025 SHALL, on valid div_load with en low, apply it on the next edge, clearing all counters.
REQ-026 SHALL let a second load before application overwrite the pending pair; only the last is applied.
REQ-027 SHALL, on sync, clear period, accumulator, carry and oversample counters with no tick that cycle; if div_load coincides and is valid, apply it immediately.
REQ-028 SHALL, with en low, hold all counters and keep all tick outputs low; resume from the held count when en rises.

Reset
REQ-029 SHALL, on rst_n low, asynchronously clear tick_ovs, tick_mid, tick_bit, cfg_err, all counters, accumulator and pending flag, and load act_int=DIV_RST, act_frac=FRAC_RST.
REQ-030 SHALL, on reset mid-period or mid-load, discard pending configuration.

Configuration
REQ-031 SHALL, with BAUD_GEN_FRAC_EN defined, implement the fractional accumulator as specified.
REQ-032 SHALL, without BAUD_GEN_FRAC_EN, omit the accumulator, ignore div_frac and FRAC_RST, and use a fixed act_int period.

Structure
REQ-033 SHALL take defaults OVS_DEF, DIV_MIN=2 and the 12 MHz preset table (9600: 78/2, 19200: 39/1, 38400: 19/9, 57600: 13/0, 115200: 6/8) from shared package baud_gen_pkg.
REQ-034 SHALL place period counter plus fractional accumulator in sub-module baud_div_core; the top holds config shadowing and oversample counting.

Verification
REQ-035 SHALL check: 57600 preset (13/0), en high -> tick_ovs every 13 cycles, tick_bit every 208, tick_mid 104 cycles after each tick_bit.
REQ-036 SHALL check: reset defaults 78/2, en high -> 8 consecutive tick_ovs periods total 625 cycles, exactly one of 79.
REQ-037 SHALL check: div_load div_int=1 -> cfg_err one cycle, tick period stays 78/79.
REQ-038 SHALL check: div_load 6/0 at period count 40 of 78 -> that period ends at 78, following periods 6.
REQ-039 SHALL check: sync at period count 10 -> no tick that cycle, next tick_ovs after act_int cycles, oversample count 0.
REQ-040 SHALL check: rst_n low for one cycle mid-bit -> outputs low immediately, first tick_ovs 78 cycles after release.
